// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and helpers for the LED pattern sequencer.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_WALK     = 2'd0,
        MODE_BOUNCE   = 2'd1,
        MODE_FILL     = 2'd2,
        MODE_ALLBLINK = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_WALK:     n = MODE_BOUNCE;
            MODE_BOUNCE:   n = MODE_FILL;
            MODE_FILL:     n = MODE_ALLBLINK;
            MODE_ALLBLINK: n = MODE_WALK;
            default:       n = MODE_WALK;
        endcase
        return n;
    endfunction

    // One bit of the value the led bus loads on entering mode m.
    function automatic logic entry_bit(input mode_e m, input int bit_idx, input int led_w);
        logic b;
        case (m)
            MODE_WALK,
            MODE_BOUNCE:   b = (bit_idx == 0);
            MODE_FILL:     b = 1'b0;
            MODE_ALLBLINK: b = (bit_idx < led_w);
            default:       b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Step timebase: divides clk by DIV while enabled; the count holds while disabled.
module tick_prescaler #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Four-mode LED pattern generator with step timebase, auto/manual mode advance and blink counter.
module led_pattern_sequencer
    import led_pattern_pkg::*;
#(
    parameter int LED_W          = 40,
    parameter int BLINK_W        = 4,
    parameter int STEP_DIV       = 25_000_000,
    parameter int STEPS_PER_MODE = 80
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode_adv,
    output logic [LED_W-1:0]   led,
    output logic [BLINK_W-1:0] blink,
    output logic [1:0]         mode,
    output logic               step_tick
);

    localparam int SC_W = $clog2(STEPS_PER_MODE + 1);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEPS_PER_MODE - 1);
    localparam logic [LED_W-1:0] LED_RESET = {{(LED_W-1){1'b0}}, 1'b1};

    mode_e              mode_q, mode_d;
    logic [SC_W-1:0]    step_cnt_q, step_cnt_d;
    logic               dir_up_q, dir_up_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               step_tick_q, step_tick_d;
    logic               adv_sync_q, adv_prev_q;

    logic               tick;
    logic               adv_rise;
    logic               advance;
    logic [LED_W-1:0]   entry_val;

    tick_prescaler #(
        .DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // Manual and automatic advance collapse into one request, so coincident events advance once.
    assign adv_rise = adv_sync_q & ~adv_prev_q;
    assign advance  = adv_rise || (tick && (step_cnt_q == STEP_LAST));

    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_entry
            assign entry_val[gi] = entry_bit(mode_d, gi, LED_W);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_WALK;
            step_cnt_q  <= '0;
            dir_up_q    <= 1'b1;
            led_q       <= LED_RESET;
            blink_q     <= '0;
            step_tick_q <= 1'b0;
            adv_sync_q  <= 1'b0;
            adv_prev_q  <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            step_cnt_q  <= step_cnt_d;
            dir_up_q    <= dir_up_d;
            led_q       <= led_d;
            blink_q     <= blink_d;
            step_tick_q <= step_tick_d;
            adv_sync_q  <= mode_adv;
            adv_prev_q  <= adv_sync_q;
        end
    end

    // Bounce direction flips on the step that lights an end bit, so the end stays lit one step.
    always_comb begin
        mode_d     = mode_q;
        step_cnt_d = step_cnt_q;
        dir_up_d   = dir_up_q;
        if (advance) begin
            mode_d     = next_mode(mode_q);
            step_cnt_d = '0;
            dir_up_d   = 1'b1;
        end else if (tick) begin
            step_cnt_d = step_cnt_q + 1'b1;
            if (mode_q == MODE_BOUNCE) begin
                if (dir_up_q && led_q[LED_W-2]) begin
                    dir_up_d = 1'b0;
                end else if (!dir_up_q && led_q[1]) begin
                    dir_up_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        led_d       = led_q;
        blink_d     = blink_q;
        step_tick_d = tick;
        if (tick) begin
            blink_d = blink_q + 1'b1;
        end
        if (advance) begin
            led_d = entry_val;
        end else if (tick) begin
            case (mode_q)
                MODE_WALK:     led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_BOUNCE:   led_d = dir_up_q ? (led_q << 1) : (led_q >> 1);
                MODE_FILL:     led_d = (&led_q) ? '0 : {led_q[LED_W-2:0], 1'b1};
                MODE_ALLBLINK: led_d = ~led_q;
                default:       led_d = led_q;
            endcase
        end
    end

    assign led       = led_q;
    assign blink     = blink_q;
    assign mode      = mode_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench: short-mode instance for mode/advance/enable behaviour, long-mode instance for pattern wraps.
module tb_led_pattern_sequencer;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          mode_adv;
    logic          mode_adv_l;
    logic [LW-1:0] led, led_l;
    logic [3:0]    blink, blink_l;
    logic [1:0]    mode, mode_l;
    logic          step_tick, step_tick_l;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] walk_main [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01, 8'h02, 8'h04};
    logic [1:0] walk_mode [8]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [7:0] walk_long [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] fill_main [5]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    logic [7:0] blink_main [5] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [7:0] bounce_long [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_long [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                   8'h00, 8'h01};

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .LED_W(LW), .BLINK_W(4), .STEP_DIV(4), .STEPS_PER_MODE(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_adv(mode_adv),
        .led(led), .blink(blink), .mode(mode), .step_tick(step_tick)
    );

    led_pattern_sequencer #(
        .LED_W(LW), .BLINK_W(4), .STEP_DIV(4), .STEPS_PER_MODE(40)
    ) dut_long (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_adv(mode_adv_l),
        .led(led_l), .blink(blink_l), .mode(mode_l), .step_tick(step_tick_l)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the next step pulse and checks the clocks taken to reach it.
    task automatic next_step(input int exp_cyc, input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (step_tick !== 1'b1 && cyc < 16);
        check_eq({tag, "_tick"}, 64'(step_tick), 64'd1);
        check_eq({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        $display("%s: cyc=%0d led=%02h blink=%0d mode=%0d | long led=%02h blink=%0d mode=%0d",
                 tag, cyc, led, blink, mode, led_l, blink_l, mode_l);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode_adv = 1'b0; mode_adv_l = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_led", 64'(led), 64'h01);
        check_eq("rst_blink", 64'(blink), 64'd0);
        check_eq("rst_mode", 64'(mode), 64'd0);
        check_eq("rst_tick", 64'(step_tick), 64'd0);
        check_eq("rst_long_led", 64'(led_l), 64'h01);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("idle_blink", 64'(blink), 64'd0);
        check_eq("idle_tick", 64'(step_tick), 64'd0);
        $display("reset: led=%02h blink=%0d mode=%0d", led, blink, mode);

        // WALK, auto advance into BOUNCE after six steps; long instance shows the full rotation
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_step((i == 1) ? 3 : 4, $sformatf("walk%0d", i));
            check_eq($sformatf("walk%0d_led", i), 64'(led), 64'(walk_main[i]));
            check_eq($sformatf("walk%0d_mode", i), 64'(mode), 64'(walk_mode[i]));
            check_eq($sformatf("walk%0d_blink", i), 64'(blink), 64'((i + 1) & 15));
            check_eq($sformatf("walk%0d_long_led", i), 64'(led_l), 64'(walk_long[i]));
            check_eq($sformatf("walk%0d_long_mode", i), 64'(mode_l), 64'd0);
            if (i == 0) begin
                @(negedge clk);
                check_eq("tick_pulse_width", 64'(step_tick), 64'd0);
            end
        end

        // mode_adv held high 20 clocks in BOUNCE: one advance to FILL
        mode_adv = 1'b1;
        @(negedge clk);
        check_eq("adv_edge1_mode", 64'(mode), 64'd1);
        @(negedge clk);
        check_eq("adv_edge2_mode", 64'(mode), 64'd2);
        check_eq("adv_edge2_led", 64'(led), 64'h00);
        check_eq("adv_edge2_blink", 64'(blink), 64'd8);
        $display("adv held: led=%02h blink=%0d mode=%0d", led, blink, mode);
        for (int i = 0; i < 5; i++) begin
            next_step((i == 0) ? 2 : 4, $sformatf("fill%0d", i));
            check_eq($sformatf("fill%0d_led", i), 64'(led), 64'(fill_main[i]));
            check_eq($sformatf("fill%0d_mode", i), 64'(mode), 64'd2);
            check_eq($sformatf("fill%0d_blink", i), 64'(blink), 64'((9 + i) & 15));
        end
        mode_adv = 1'b0;

        // en low mid-step for 10 clocks with a mode_adv pulse inside
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq($sformatf("frozen%0d_tick", k), 64'(step_tick), 64'd0);
            check_eq($sformatf("frozen%0d_blink", k), 64'(blink), 64'd13);
            if (k == 1) check_eq("frozen_led_fill", 64'(led), 64'h1F);
            if (k == 2) mode_adv = 1'b1;
            if (k == 3) mode_adv = 1'b0;
        end
        check_eq("frozen_adv_mode", 64'(mode), 64'd3);
        check_eq("frozen_adv_led", 64'(led), 64'hFF);
        $display("frozen: led=%02h blink=%0d mode=%0d", led, blink, mode);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_step((i == 0) ? 2 : 4, $sformatf("allblink%0d", i));
            check_eq($sformatf("allblink%0d_led", i), 64'(led), 64'(blink_main[i]));
            check_eq($sformatf("allblink%0d_mode", i), 64'(mode), 64'd3);
            check_eq($sformatf("allblink%0d_blink", i), 64'(blink), 64'((14 + i) & 15));
        end

        // mode_adv rise coincides with the sixth-step tick
        repeat (2) @(negedge clk);
        mode_adv = 1'b1;
        @(negedge clk);
        check_eq("coinc_pre_mode", 64'(mode), 64'd3);
        next_step(1, "coinc");
        check_eq("coinc_mode", 64'(mode), 64'd0);
        check_eq("coinc_led", 64'(led), 64'h01);
        check_eq("coinc_blink", 64'(blink), 64'd3);
        mode_adv = 1'b0;
        next_step(4, "coinc_after1");
        check_eq("coinc_after1_mode", 64'(mode), 64'd0);
        check_eq("coinc_after1_led", 64'(led), 64'h02);
        next_step(4, "coinc_after2");
        check_eq("coinc_after2_led", 64'(led), 64'h04);
        check_eq("coinc_after2_blink", 64'(blink), 64'd5);

        // asynchronous reset between clock edges while step_tick is high
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", 64'(led), 64'h01);
        check_eq("async_rst_blink", 64'(blink), 64'd0);
        check_eq("async_rst_mode", 64'(mode), 64'd0);
        check_eq("async_rst_tick", 64'(step_tick), 64'd0);
        check_eq("async_rst_long_blink", 64'(blink_l), 64'd0);
        $display("async reset: led=%02h blink=%0d mode=%0d tick=%0d", led, blink, mode, step_tick);
        @(negedge clk);
        rst_n = 1'b1;

        // long instance: full WALK rotation, BOUNCE reversal at both ends, FILL wrap to zero
        for (int i = 0; i < 8; i++) begin
            next_step(4, $sformatf("lwalk%0d", i));
            check_eq($sformatf("lwalk%0d_led", i), 64'(led_l), 64'(walk_long[i]));
            check_eq($sformatf("lwalk%0d_blink", i), 64'(blink_l), 64'((i + 1) & 15));
        end
        mode_adv_l = 1'b1;
        @(negedge clk);
        mode_adv_l = 1'b0;
        @(negedge clk);
        check_eq("lbounce_entry_mode", 64'(mode_l), 64'd1);
        check_eq("lbounce_entry_led", 64'(led_l), 64'h01);
        for (int i = 0; i < 15; i++) begin
            next_step((i == 0) ? 2 : 4, $sformatf("lbounce%0d", i));
            check_eq($sformatf("lbounce%0d_led", i), 64'(led_l), 64'(bounce_long[i]));
            check_eq($sformatf("lbounce%0d_mode", i), 64'(mode_l), 64'd1);
            check_eq($sformatf("lbounce%0d_blink", i), 64'(blink_l), 64'((9 + i) & 15));
        end
        mode_adv_l = 1'b1;
        @(negedge clk);
        mode_adv_l = 1'b0;
        @(negedge clk);
        check_eq("lfill_entry_mode", 64'(mode_l), 64'd2);
        check_eq("lfill_entry_led", 64'(led_l), 64'h00);
        for (int i = 0; i < 10; i++) begin
            next_step((i == 0) ? 2 : 4, $sformatf("lfill%0d", i));
            check_eq($sformatf("lfill%0d_led", i), 64'(led_l), 64'(fill_long[i]));
            check_eq($sformatf("lfill%0d_mode", i), 64'(mode_l), 64'd2);
            check_eq($sformatf("lfill%0d_blink", i), 64'(blink_l), 64'((24 + i) & 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
